// File: rtl/dmem_trace_pkg.sv
// rtl/dmem_trace_pkg.sv - shared wen patterns, entry field widths and layout helpers for the store tracer (TRACE_TIMESTAMP_EN adds the time field)
package dmem_trace_pkg;

  localparam logic [3:0] WEN_WORD    = 4'b1111;
  localparam logic [3:0] WEN_HALF_LO = 4'b0011;
  localparam logic [3:0] WEN_HALF_HI = 4'b1100;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WEN_W  = 4;
  localparam int TIME_W = 32;

  // Packed entry layout, MSB first: {bad_be, seq, wen, addr, data[, time]}
  function automatic int entry_width(input int seq_w);
`ifdef TRACE_TIMESTAMP_EN
    return 1 + seq_w + WEN_W + ADDR_W + DATA_W + TIME_W;
`else
    return 1 + seq_w + WEN_W + ADDR_W + DATA_W;
`endif
  endfunction

  // Word, aligned half-words, or a single byte lane matching the low address bits
  function automatic logic be_legal(input logic [3:0] wen, input logic [1:0] off);
    logic single_hot;
    single_hot = (wen == (4'b0001 << off));
    return ((wen == WEN_WORD)    && (off == 2'd0)) ||
           ((wen == WEN_HALF_LO) && (off == 2'd0)) ||
           ((wen == WEN_HALF_HI) && (off == 2'd2)) ||
           single_hot;
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// rtl/trace_sync_fifo.sv - generic show-ahead synchronous FIFO with wrap-bit pointers
module trace_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is presented combinationally; an empty FIFO shows zeros rather than stale storage
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; clear overrides any push or pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; cells need no reset because they are only visible while occupied
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dmem_store_tracer.sv
// rtl/dmem_store_tracer.sv - snoops CPU stores in an address window into a trace FIFO (TRACE_TIMESTAMP_EN adds trace_time)
module dmem_store_tracer
  import dmem_trace_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] WIN_BASE  = 32'h0000_0100,
  parameter logic [31:0] WIN_BYTES = 32'h0000_0100,
  parameter int          SEQ_W     = 16,
  parameter int          CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              d_mem_addr,
  input  logic [31:0]              d_mem_wdata,
  input  logic [3:0]               d_mem_wen,
  input  logic                     flush,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_addr,
  output logic [31:0]              trace_data,
  output logic [3:0]               trace_wen,
  output logic [SEQ_W-1:0]         trace_seq,
  output logic                     trace_bad_be,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [TIME_W-1:0]        trace_time
`endif
);

  localparam int EW = entry_width(SEQ_W);

  logic [32:0]      win_off;
  logic             in_win;
  logic             bad_be;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [SEQ_W-1:0] seq_cnt;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;

  // 33-bit offset so a window near the top of the address space cannot wrap
  assign win_off = {1'b0, d_mem_addr} - {1'b0, WIN_BASE};
  assign in_win  = (d_mem_wen != 4'b0000) && (d_mem_addr >= WIN_BASE) &&
                   (win_off < {1'b0, WIN_BYTES});
  assign bad_be  = !be_legal(d_mem_wen, d_mem_addr[1:0]);

  assign trace_valid = !empty;
  assign pop         = trace_valid && trace_ready;
  assign push        = in_win && !flush;
  assign drop        = push && full && !pop;

`ifdef TRACE_TIMESTAMP_EN
  logic [TIME_W-1:0] time_cnt;

  // Free-running cycle counter stamped into each entry at capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) time_cnt <= '0;
    else        time_cnt <= time_cnt + TIME_W'(1);
  end

  assign wr_entry = {bad_be, seq_cnt, d_mem_wen, d_mem_addr, d_mem_wdata, time_cnt};
  assign {trace_bad_be, trace_seq, trace_wen, trace_addr, trace_data, trace_time} = rd_entry;
`else
  assign wr_entry = {bad_be, seq_cnt, d_mem_wen, d_mem_addr, d_mem_wdata};
  assign {trace_bad_be, trace_seq, trace_wen, trace_addr, trace_data} = rd_entry;
`endif

  // Every in-window store consumes a sequence number, even when dropped or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      seq_cnt <= '0;
    else if (in_win) seq_cnt <= seq_cnt + SEQ_W'(1);
  end

  // Sticky loss indication; survives flush, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + CNT_W'(1);
    end
  end

  trace_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

endmodule
